// File: rtl/switch_pkg.sv
// Shared switch-wide constants and types for the 4-port ingress/egress logic.
package switch_pkg;

  localparam int PORT_NUM = 4;
  localparam int DESC_W   = 8;

  typedef logic [1:0] port_idx_t;

endpackage

// File: rtl/voq_bank_fifo.sv
// One virtual output queue: circular buffer with registered count and
// empty/full flags derived from the next-state count.
module voq_fifo
  import switch_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = DESC_W,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_empty;
  logic              r_full;

  logic              w_wr_fire;
  logic              w_rd_fire;
  logic [CW-1:0]     w_count_nxt;

  // Strobes are re-qualified locally so the FIFO never overruns or underruns
  // even if a caller forgets to gate them.
  assign w_wr_fire = wr_en && !r_full;
  assign w_rd_fire = rd_en && !r_empty;

  // Occupancy next-state: a simultaneous push and pop leave it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_fire && !w_rd_fire)
      w_count_nxt = r_count + CW'(1);
    else if (w_rd_fire && !w_wr_fire)
      w_count_nxt = r_count - CW'(1);
  end

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (!reset && w_wr_fire)
      r_mem[r_wr_ptr] <= wr_data;
  end

  // Pointers, count and flags; pointers wrap naturally since DEPTH is 2^AW.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_wr_fire) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_fire) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CW'(DEPTH));
    end
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;
  assign empty   = r_empty;
  assign full    = r_full;

endmodule

// File: rtl/voq_bank.sv
// Bank of four VOQs: decodes enqueue destination and dequeue index into
// per-queue strobes, and registers the selected head as the dequeue result.
module voq_bank
  import switch_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = DESC_W,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_valid,
  input  logic [1:0]             enq_dest,
  input  logic [DATA_W-1:0]      enq_data,
  output logic                   enq_ready,
  input  logic                   deq_en,
  input  logic [1:0]             deq_voq,
  output logic                   deq_valid,
  output logic [DATA_W-1:0]      deq_data,
  output logic                   deq_err,
  output logic [PORT_NUM-1:0]    voq_empty,
  output logic [PORT_NUM-1:0]    voq_full,
  output logic [PORT_NUM*CW-1:0] voq_count
);

  logic [DATA_W-1:0]   w_head [PORT_NUM];
  logic [PORT_NUM-1:0] w_wr_en;
  logic [PORT_NUM-1:0] w_rd_en;
  logic                w_enq_fire;
  logic                w_deq_fire;
  logic                w_deq_miss;

  logic                r_vld_p1;
  logic                r_err_p1;
  logic [DATA_W-1:0]   r_data_p1;

  // Ready looks only at registered full and the offered destination.
  assign enq_ready  = !voq_full[enq_dest];
  assign w_enq_fire = enq_valid && enq_ready;
  assign w_deq_fire = deq_en && !voq_empty[deq_voq];
  assign w_deq_miss = deq_en && voq_empty[deq_voq];

  // One-hot strobe decode for the addressed queues.
  always_comb begin
    w_wr_en = '0;
    w_rd_en = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      w_wr_en[i] = w_enq_fire && (port_idx_t'(enq_dest) == port_idx_t'(i));
      w_rd_en[i] = w_deq_fire && (port_idx_t'(deq_voq) == port_idx_t'(i));
    end
  end

  for (genvar g = 0; g < PORT_NUM; g++) begin : g_voq
    voq_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (w_wr_en[g]),
      .wr_data (enq_data),
      .rd_en   (w_rd_en[g]),
      .rd_data (w_head[g]),
      .count   (voq_count[g*CW +: CW]),
      .empty   (voq_empty[g]),
      .full    (voq_full[g])
    );
  end

  // p0 -> p1: register selected head; data holds when nothing is dequeued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1  <= 1'b0;
      r_err_p1  <= 1'b0;
      r_data_p1 <= '0;
    end else begin
      r_vld_p1 <= w_deq_fire;
      r_err_p1 <= w_deq_miss;
      if (w_deq_fire)
        r_data_p1 <= w_head[deq_voq];
    end
  end

  assign deq_valid = r_vld_p1;
  assign deq_err   = r_err_p1;
  assign deq_data  = r_data_p1;

endmodule

// File: tb/tb_voq_bank.sv
// Directed, table-driven bench for voq_bank with hand-computed expectations.
module tb_voq_bank;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 8;
  localparam int CW     = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enq_valid;
  logic [1:0]    enq_dest;
  logic [7:0]    enq_data;
  logic          enq_ready;
  logic          deq_en;
  logic [1:0]    deq_voq;
  logic          deq_valid;
  logic [7:0]    deq_data;
  logic          deq_err;
  logic [3:0]    voq_empty;
  logic [3:0]    voq_full;
  logic [15:0]   voq_count;

  int n_pass  = 0;
  int n_total = 0;

  voq_bank #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .enq_valid (enq_valid),
    .enq_dest  (enq_dest),
    .enq_data  (enq_data),
    .enq_ready (enq_ready),
    .deq_en    (deq_en),
    .deq_voq   (deq_voq),
    .deq_valid (deq_valid),
    .deq_data  (deq_data),
    .deq_err   (deq_err),
    .voq_empty (voq_empty),
    .voq_full  (voq_full),
    .voq_count (voq_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ev;
    logic [1:0] ed;
    logic [7:0] dd;
    logic       de;
    logic [1:0] dv;
    logic       rdy;
    logic       vld;
    logic [7:0] dat;
    logic       err;
    logic [3:0] emp;
    logic [3:0] ful;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic apply(input logic ev, input logic [1:0] ed, input logic [7:0] dd,
                       input logic de, input logic [1:0] dv, input logic rst_i);
    @(negedge clk);
    enq_valid = ev;
    enq_dest  = ed;
    enq_data  = dd;
    deq_en    = de;
    deq_voq   = dv;
    reset     = rst_i;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] d;

    // Reset and idle state
    apply(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1);
    tick;
    apply(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0);
    chk("rst_empty", 32'(voq_empty), 32'h0000000f);
    chk("rst_full",  32'(voq_full),  32'h0);
    chk("rst_count", 32'(voq_count), 32'h0);
    chk("rst_vld",   32'(deq_valid), 32'h0);
    chk("rst_err",   32'(deq_err),   32'h0);
    chk("rst_data",  32'(deq_data),  32'h0);
    for (int p = 0; p < 4; p++) begin
      apply(1'b0, 2'(p), 8'h00, 1'b0, 2'd0, 1'b0);
      chk("rst_ready", 32'(enq_ready), 32'h1);
    end

    // FIFO order on VOQ2, same-cycle enq/deq on empty VOQ3, cross-VOQ traffic
    tbl[0]  = '{1'b1, 2'd2, 8'h11, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 4'b1011, 4'b0000, 16'h0100};
    tbl[1]  = '{1'b1, 2'd2, 8'h22, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 4'b1011, 4'b0000, 16'h0200};
    tbl[2]  = '{1'b1, 2'd2, 8'h33, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 4'b1011, 4'b0000, 16'h0300};
    tbl[3]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b1, 1'b1, 8'h11, 1'b0, 4'b1011, 4'b0000, 16'h0200};
    tbl[4]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b1, 1'b1, 8'h22, 1'b0, 4'b1011, 4'b0000, 16'h0100};
    tbl[5]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b1, 1'b1, 8'h33, 1'b0, 4'b1111, 4'b0000, 16'h0000};
    tbl[6]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 8'h33, 1'b0, 4'b1111, 4'b0000, 16'h0000};
    tbl[7]  = '{1'b1, 2'd3, 8'h44, 1'b1, 2'd3, 1'b1, 1'b0, 8'h33, 1'b1, 4'b0111, 4'b0000, 16'h1000};
    tbl[8]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b1, 1'b1, 8'h44, 1'b0, 4'b1111, 4'b0000, 16'h0000};
    tbl[9]  = '{1'b1, 2'd0, 8'h55, 1'b1, 2'd2, 1'b1, 1'b0, 8'h44, 1'b1, 4'b1110, 4'b0000, 16'h0001};
    tbl[10] = '{1'b1, 2'd1, 8'h66, 1'b1, 2'd0, 1'b1, 1'b1, 8'h55, 1'b0, 4'b1101, 4'b0000, 16'h0010};
    tbl[11] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b1, 1'b1, 8'h66, 1'b0, 4'b1111, 4'b0000, 16'h0000};

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].ev, tbl[i].ed, tbl[i].dd, tbl[i].de, tbl[i].dv, 1'b0);
      chk("tbl_ready", 32'(enq_ready), 32'(tbl[i].rdy));
      tick;
      chk("tbl_vld",   32'(deq_valid), 32'(tbl[i].vld));
      chk("tbl_data",  32'(deq_data),  32'(tbl[i].dat));
      chk("tbl_err",   32'(deq_err),   32'(tbl[i].err));
      chk("tbl_empty", 32'(voq_empty), 32'(tbl[i].emp));
      chk("tbl_full",  32'(voq_full),  32'(tbl[i].ful));
      chk("tbl_count", 32'(voq_count), 32'(tbl[i].cnt));
    end

    // Fill VOQ1 to DEPTH
    for (int k = 0; k < DEPTH; k++) begin
      d = 8'hA0 + 8'(k);
      apply(1'b1, 2'd1, d, 1'b0, 2'd0, 1'b0);
      chk("fill_ready", 32'(enq_ready), 32'h1);
      tick;
    end
    chk("fill_full",  32'(voq_full),  32'h2);
    chk("fill_count", 32'(voq_count), 32'h0080);
    // Ninth offer refused
    apply(1'b1, 2'd1, 8'hFF, 1'b0, 2'd0, 1'b0);
    chk("full_ready", 32'(enq_ready), 32'h0);
    tick;
    chk("ninth_count", 32'(voq_count), 32'h0080);
    chk("ninth_full",  32'(voq_full),  32'h2);
    // Enqueue still refused while a dequeue of the full VOQ proceeds
    apply(1'b1, 2'd1, 8'hFF, 1'b1, 2'd1, 1'b0);
    chk("fulldeq_ready", 32'(enq_ready), 32'h0);
    tick;
    chk("fulldeq_vld",   32'(deq_valid), 32'h1);
    chk("fulldeq_data",  32'(deq_data),  32'hA0);
    chk("fulldeq_full",  32'(voq_full),  32'h0);
    chk("fulldeq_count", 32'(voq_count), 32'h0070);
    apply(1'b0, 2'd1, 8'h00, 1'b0, 2'd0, 1'b0);
    chk("after_ready", 32'(enq_ready), 32'h1);
    for (int k = 1; k < DEPTH; k++) begin
      apply(1'b0, 2'd1, 8'h00, 1'b1, 2'd1, 1'b0);
      tick;
      chk("drain1_vld",  32'(deq_valid), 32'h1);
      chk("drain1_data", 32'(deq_data),  32'(8'hA0 + 8'(k)));
    end
    chk("drain1_empty", 32'(voq_empty), 32'hf);

    // Pointer wrap on VOQ0 with occupancy held at 2
    apply(1'b1, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0);
    tick;
    apply(1'b1, 2'd0, 8'h01, 1'b0, 2'd0, 1'b0);
    tick;
    for (int k = 0; k < 20; k++) begin
      apply(1'b1, 2'd0, 8'(k + 2), 1'b1, 2'd0, 1'b0);
      tick;
      chk("wrap_vld",   32'(deq_valid),      32'h1);
      chk("wrap_data",  32'(deq_data),       32'(k));
      chk("wrap_count", 32'(voq_count[3:0]), 32'h2);
    end
    for (int k = 20; k < 22; k++) begin
      apply(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b0);
      tick;
      chk("wrap_tail", 32'(deq_data), 32'(k));
    end
    chk("wrap_empty", 32'(voq_empty), 32'hf);

    // Reset mid-operation with a dequeue pending and an enqueue offered
    apply(1'b1, 2'd0, 8'h77, 1'b0, 2'd0, 1'b0);
    tick;
    apply(1'b1, 2'd3, 8'h88, 1'b0, 2'd0, 1'b0);
    tick;
    chk("load_empty", 32'(voq_empty), 32'h6);
    apply(1'b1, 2'd3, 8'h99, 1'b1, 2'd0, 1'b1);
    tick;
    chk("mrst_vld",   32'(deq_valid), 32'h0);
    chk("mrst_err",   32'(deq_err),   32'h0);
    chk("mrst_data",  32'(deq_data),  32'h0);
    chk("mrst_empty", 32'(voq_empty), 32'hf);
    chk("mrst_full",  32'(voq_full),  32'h0);
    chk("mrst_count", 32'(voq_count), 32'h0);
    apply(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b0);
    tick;
    chk("post_rst_err", 32'(deq_err),   32'h1);
    chk("post_rst_vld", 32'(deq_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
